// File: rtl/adder_share_sched.sv
// adder_share_sched
//   Round-robin arbiter in front of one shared SLICE-bit ripple-carry adder.
//   An accepted WIDTH-bit add is processed one slice per clock, least
//   significant slice first. The carry between slices is held in a register.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst        : synchronous, active-high reset
//   req        : per-requester level request, held until granted
//   a_in, b_in : packed operands; requester i uses bits [i*WIDTH +: WIDTH]
//   cin_in     : per-requester carry-in
//   gnt        : one-hot, one-cycle pulse marking the accepting edge
//   busy       : high while an operation is in CALC or DONE
//   done       : one-cycle pulse; sum/cout/done_id are valid
//   done_id    : index of the requester that owns sum/cout
//   sum, cout  : result; held from one done pulse until the next
//   state_dbg  : current FSM state (IDLE=0, CALC=1, DONE=2)
//
// Handshake: req is a level held by the requester. The request is accepted
// on the edge where the FSM is IDLE and this requester wins arbitration.
// That acceptance is shown by a one-cycle gnt pulse in the following cycle.
// The operands are captured on that same edge only.
module adder_share_sched #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  parameter int NREQ  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  input  logic [NREQ-1:0]       cin_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [WIDTH-1:0]      sum,
  output logic                  cout,
  output logic [1:0]            state_dbg
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;       // highest-priority requester
  logic [IDW-1:0]    gidx_q, gidx_d;     // requester being served
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;       // partial result, never on sum
  logic              carry_q, carry_d;
  logic [KW-1:0]     k_q, k_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              done_q, done_d;
  logic [IDW-1:0]    done_id_q, done_id_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  // Round-robin search starting at ptr_q.
  logic              found;
  logic [IDW-1:0]    pick;

  always_comb begin
    int idx;
    found = 1'b0;
    pick  = ptr_q;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  // The single shared slice adder.
  logic [SLICE-1:0]  a_sl, b_sl;
  logic [SLICE:0]    sl_sum;
  logic [WIDTH-1:0]  res_full;

  always_comb begin
    a_sl     = a_q[k_q*SLICE +: SLICE];
    b_sl     = b_q[k_q*SLICE +: SLICE];
    sl_sum   = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
    res_full = acc_q;
    res_full[k_q*SLICE +: SLICE] = sl_sum[SLICE-1:0];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    k_d       = k_q;
    gnt_d     = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    sum_d     = sum_q;
    cout_d    = cout_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d   = NREQ'(1) << pick;
          gidx_d  = pick;
          a_d     = a_in[pick*WIDTH +: WIDTH];
          b_d     = b_in[pick*WIDTH +: WIDTH];
          carry_d = cin_in[pick];
          acc_d   = '0;
          k_d     = '0;
          // The winner drops behind everyone else.
          ptr_d   = (pick == IDW'(NREQ - 1)) ? '0 : pick + IDW'(1);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d   = res_full;
        carry_d = sl_sum[SLICE];
        if (k_q == KW'(NSLICE - 1)) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          sum_d     = res_full;
          cout_d    = sl_sum[SLICE];
          done_id_d = gidx_q;
          k_d       = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        // No request is accepted here; arbitration resumes in IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      k_q       <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      k_q       <= k_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign state_dbg = state_q;

endmodule
